// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the IF stage: NPC operation encodings, default
// reset PC, the NOP word used for bubbles, and a saturating counter helper.
package instruction_fetch_unit_pkg;

    // NPC operation returned from EX (same encoding as defines.vh NPC_*)
    typedef enum logic [1:0] {
        NPC_PC4  = 2'd0,
        NPC_JAL  = 2'd1,
        NPC_JALR = 2'd2,
        NPC_B    = 2'd3
    } npc_op_e;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013; // addi x0,x0,0

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == '1) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_npc_target_select.sv
// Redirect decision and target computation for the instruction in EX.
// Purely combinational; the target is always word aligned and the
// misalignment flag reports whether bit1 of the raw target was set.
module npc_target_select
    import instruction_fetch_unit_pkg::*;
(
    input  logic        ex_valid,
    input  logic [1:0]  npc_op,
    input  logic        branch_taken,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic [31:0] alu_result,
    output logic        redirect,
    output logic [31:0] target,
    output logic        target_misaligned
);

    logic [31:0] raw_target;

    // Decode the NPC op into a redirect request and its raw target address
    always_comb begin
        redirect   = 1'b0;
        raw_target = ex_pc + ex_imm;
        case (npc_op_e'(npc_op))
            NPC_JAL:  redirect = ex_valid;
            NPC_B:    redirect = ex_valid & branch_taken;
            NPC_JALR: begin
                redirect   = ex_valid;
                raw_target = alu_result & 32'hFFFF_FFFE;
            end
            default:  redirect = 1'b0;
        endcase
        target            = raw_target & 32'hFFFF_FFFC;
        target_misaligned = raw_target[1];
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: PC register, combinational IROM address, IF/ID pipeline
// register, and redirect/squash handling for resolved control flow in EX.
// Static predict-not-taken; a taken redirect squashes IF/ID and ID.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        ExValid,
    input  logic [1:0]  ExNpcOperation,
    input  logic        ExBranchTaken,
    input  logic [31:0] ExPc,
    input  logic [31:0] ExImmediate,
    input  logic [31:0] ExAluResult,
    output logic [31:0] IromAddress,
    input  logic [31:0] IromData,
    output logic [31:0] IfIdInstruction,
    output logic [31:0] IfIdPc,
    output logic [31:0] IfIdPc4,
    output logic        IfIdValid,
    output logic        FlushIdEx,
    output logic        Misaligned,
    output logic [31:0] FetchCount,
    output logic [15:0] FlushCount
);

    logic [31:0] pc;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        target_misaligned;

    npc_target_select u_npc_target_select (
        .ex_valid          (ExValid),
        .npc_op            (ExNpcOperation),
        .branch_taken      (ExBranchTaken),
        .ex_pc             (ExPc),
        .ex_imm            (ExImmediate),
        .alu_result        (ExAluResult),
        .redirect          (redirect),
        .target            (redirect_target),
        .target_misaligned (target_misaligned)
    );

    assign IromAddress = pc;
    assign FlushIdEx   = redirect;

    // PC, IF/ID register and counters: redirect beats stall beats fetch
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pc              <= RESET_PC;
            IfIdInstruction <= NOP_INSTR;
            IfIdPc          <= '0;
            IfIdPc4         <= '0;
            IfIdValid       <= 1'b0;
            Misaligned      <= 1'b0;
            FetchCount      <= '0;
            FlushCount      <= '0;
        end else if (redirect) begin
            pc              <= redirect_target;
            IfIdInstruction <= NOP_INSTR;
            IfIdPc          <= '0;
            IfIdPc4         <= '0;
            IfIdValid       <= 1'b0;
            Misaligned      <= Misaligned | target_misaligned;
            FlushCount      <= sat_inc16(FlushCount);
        end else if (!Stall) begin
            pc              <= pc + 32'd4;
            IfIdInstruction <= IromData;
            IfIdPc          <= pc;
            IfIdPc4         <= pc + 32'd4;
            IfIdValid       <= 1'b1;
            FetchCount      <= FetchCount + 32'd1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: a reference model predicts
// each edge's outcome, pushes it onto a scoreboard queue, and the entry is
// popped and compared just after the edge.
module tb_instruction_fetch_unit;

    localparam logic [1:0]  OP_PC4  = 2'd0;
    localparam logic [1:0]  OP_JAL  = 2'd1;
    localparam logic [1:0]  OP_JALR = 2'd2;
    localparam logic [1:0]  OP_B    = 2'd3;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Stall = 1'b0;
    logic        ExValid = 1'b0;
    logic [1:0]  ExNpcOperation = OP_PC4;
    logic        ExBranchTaken = 1'b0;
    logic [31:0] ExPc = '0;
    logic [31:0] ExImmediate = '0;
    logic [31:0] ExAluResult = '0;
    logic [31:0] IromAddress;
    logic [31:0] IromData;
    logic [31:0] IfIdInstruction;
    logic [31:0] IfIdPc;
    logic [31:0] IfIdPc4;
    logic        IfIdValid;
    logic        FlushIdEx;
    logic        Misaligned;
    logic [31:0] FetchCount;
    logic [15:0] FlushCount;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] ifpc;
        logic [31:0] ifpc4;
        logic        valid;
        logic        mis;
        logic [31:0] fc;
        logic [15:0] flc;
    } exp_t;

    exp_t sb[$];

    // reference model state
    logic [31:0] m_pc, m_ins, m_ifpc, m_ifpc4, m_fc;
    logic        m_valid, m_mis;
    logic [15:0] m_flc;

    instruction_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .Stall           (Stall),
        .ExValid         (ExValid),
        .ExNpcOperation  (ExNpcOperation),
        .ExBranchTaken   (ExBranchTaken),
        .ExPc            (ExPc),
        .ExImmediate     (ExImmediate),
        .ExAluResult     (ExAluResult),
        .IromAddress     (IromAddress),
        .IromData        (IromData),
        .IfIdInstruction (IfIdInstruction),
        .IfIdPc          (IfIdPc),
        .IfIdPc4         (IfIdPc4),
        .IfIdValid       (IfIdValid),
        .FlushIdEx       (FlushIdEx),
        .Misaligned      (Misaligned),
        .FetchCount      (FetchCount),
        .FlushCount      (FlushCount)
    );

    always #5 Clock = ~Clock;

    function automatic logic [31:0] irom(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    assign IromData = irom(IromAddress);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ins = NOP; m_ifpc = '0; m_ifpc4 = '0;
        m_valid = 1'b0; m_mis = 1'b0; m_fc = '0; m_flc = '0;
    endtask

    task automatic check_reset_outputs();
        check("rst_pc",    IromAddress, 32'h0);
        check("rst_ins",   IfIdInstruction, NOP);
        check("rst_ifpc",  IfIdPc, 32'h0);
        check("rst_ifpc4", IfIdPc4, 32'h0);
        check("rst_valid", IfIdValid, 32'h0);
        check("rst_mis",   Misaligned, 32'h0);
        check("rst_fc",    FetchCount, 32'h0);
        check("rst_flc",   FlushCount, 32'h0);
    endtask

    // One clock: check combinational outputs, predict the edge, compare after it
    task automatic cycle();
        logic        redir;
        logic [31:0] tgt;
        exp_t        e;
        @(negedge Clock);
        redir = ExValid && (ExNpcOperation == OP_JAL || ExNpcOperation == OP_JALR ||
                            (ExNpcOperation == OP_B && ExBranchTaken));
        tgt = (ExNpcOperation == OP_JALR) ? (ExAluResult & 32'hFFFF_FFFE) : ExPc + ExImmediate;
        check("irom_addr", IromAddress, m_pc);
        check("flush_idex", FlushIdEx, redir);
        if (redir) begin
            m_pc = {tgt[31:2], 2'b00};
            if (tgt[1]) m_mis = 1'b1;
            m_ins = NOP; m_ifpc = '0; m_ifpc4 = '0; m_valid = 1'b0;
            if (m_flc != 16'hFFFF) m_flc = m_flc + 16'd1;
        end else if (!Stall) begin
            m_ins = irom(m_pc); m_ifpc = m_pc; m_ifpc4 = m_pc + 32'd4;
            m_valid = 1'b1; m_pc = m_pc + 32'd4; m_fc = m_fc + 32'd1;
        end
        e = '{pc: m_pc, ins: m_ins, ifpc: m_ifpc, ifpc4: m_ifpc4,
              valid: m_valid, mis: m_mis, fc: m_fc, flc: m_flc};
        sb.push_back(e);
        @(posedge Clock);
        #1;
        e = sb.pop_front();
        check("pc",         IromAddress, e.pc);
        check("ifid_instr", IfIdInstruction, e.ins);
        check("ifid_pc",    IfIdPc, e.ifpc);
        check("ifid_pc4",   IfIdPc4, e.ifpc4);
        check("ifid_valid", IfIdValid, e.valid);
        check("misaligned", Misaligned, e.mis);
        check("fetch_cnt",  FetchCount, e.fc);
        check("flush_cnt",  FlushCount, e.flc);
    endtask

    task automatic set_ex(input logic v, input logic [1:0] op, input logic tk,
                          input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] alu);
        ExValid = v; ExNpcOperation = op; ExBranchTaken = tk;
        ExPc = pc; ExImmediate = imm; ExAluResult = alu;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        #12;
        check_reset_outputs();
        @(posedge Clock); #1;
        Reset = 1'b0;

        // free run: IfIdPc 0,4 then stall at PC=8 for two edges, then 8,C
        repeat (2) cycle();
        Stall = 1'b1;
        repeat (2) cycle();
        check("stall_pc_held", IromAddress, 32'h8);
        check("stall_ifpc_held", IfIdPc, 32'h4);
        Stall = 1'b0;
        repeat (2) cycle();
        check("resume_ifpc", IfIdPc, 32'hC);
        check("fetch_after_4", FetchCount, 32'd4);

        // taken branch back to 0x08
        set_ex(1'b1, OP_B, 1'b1, 32'h10, 32'hFFFF_FFF8, 32'h0);
        cycle();
        check("br_pc", IromAddress, 32'h8);
        check("br_flushcnt", FlushCount, 32'd1);
        // not-taken branch: no flush
        set_ex(1'b1, OP_B, 1'b0, 32'h10, 32'hFFFF_FFF8, 32'h0);
        cycle();
        // valid flag clear: JAL op must not redirect
        set_ex(1'b0, OP_JAL, 1'b0, 32'h40, 32'h40, 32'h0);
        cycle();

        // JALR aligned after bit0 mask, then JALR with bit1 set
        set_ex(1'b1, OP_JALR, 1'b0, 32'h0, 32'h0, 32'h0000_0101);
        cycle();
        check("jalr_pc", IromAddress, 32'h100);
        set_ex(1'b1, OP_JALR, 1'b0, 32'h0, 32'h0, 32'h0000_0106);
        cycle();
        check("jalr_mis_pc", IromAddress, 32'h104);
        set_ex(1'b0, OP_PC4, 1'b0, 32'h0, 32'h0, 32'h0);
        repeat (2) cycle();
        check("mis_sticky", Misaligned, 32'h1);

        // redirect wins over a simultaneous stall
        Stall = 1'b1;
        set_ex(1'b1, OP_JAL, 1'b0, 32'h20, 32'h40, 32'h0);
        cycle();
        check("jal_stall_pc", IromAddress, 32'h60);
        Stall = 1'b0;

        // jump to the top of the address space and wrap
        set_ex(1'b1, OP_JAL, 1'b0, 32'h0, 32'hFFFF_FFFC, 32'h0);
        cycle();
        set_ex(1'b0, OP_PC4, 1'b0, 32'h0, 32'h0, 32'h0);
        cycle();
        check("wrap_pc", IromAddress, 32'h0);
        check("wrap_ifpc4", IfIdPc4, 32'h0);
        cycle();

        // async reset between edges while stalled and redirecting
        Stall = 1'b1;
        set_ex(1'b1, OP_JAL, 1'b0, 32'h20, 32'h40, 32'h0);
        #2;
        Reset = 1'b1;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge Clock); #1;
        Reset = 1'b0;
        Stall = 1'b0;
        set_ex(1'b0, OP_PC4, 1'b0, 32'h0, 32'h0, 32'h0);
        repeat (2) cycle();
        check("post_rst_ifpc", IfIdPc, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
